// File: rtl/seg_adder_mc.sv
// seg_adder_mc: multi-cycle chunked add/subtract unit with valid/ready handshakes
module seg_adder_mc #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf,
  output logic             busy
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("seg_adder_mc: WIDTH must be a multiple of CHUNK");
  end
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] a_r, b_r;
  logic carry;
  logic [IW-1:0] idx;
  logic [CHUNK:0] csum;
  logic last;
  assign csum = {1'b0, a_r[int'(idx)*CHUNK +: CHUNK]} + {1'b0, b_r[int'(idx)*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, carry};
  assign last = idx == IW'(NCHUNK - 1);
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    in_ready = state == IDLE;
    out_valid = state == DONE;
    busy = state != IDLE;
    if (state == IDLE && in_valid) nxt = CALC;
    else if (state == CALC && last) nxt = DONE;
    else if (state == DONE && out_ready) nxt = IDLE;
  end
  // subtraction is a + ~b + 1, so b is inverted and the carry forced at accept
  always_ff @(posedge clk)
    if (!rst_n) begin
      idx <= '0;
      s <= '0;
      co <= 1'b0;
      ovf <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_r <= a;
      b_r <= sub ? ~b : b;
      carry <= sub | cin;
      idx <= '0;
    end else if (state == CALC) begin
      s[int'(idx)*CHUNK +: CHUNK] <= csum[CHUNK-1:0];
      carry <= csum[CHUNK];
      idx <= last ? '0 : idx + IW'(1);
      if (last) begin
        co <= csum[CHUNK];
        ovf <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (csum[CHUNK-1] != a_r[WIDTH-1]);
      end
    end
endmodule

// File: tb/tb_seg_adder_mc.sv
// tb_seg_adder_mc: random and directed checks of seg_adder_mc against an arithmetic model
module tb_seg_adder_mc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic iv[2], orr[2], cin[2], sub[2], ir[2], ov[2], bz[2], co[2], ovf[2];
  logic [15:0] a[2], b[2];
  logic [15:0] s16;
  logic [7:0] s8;
  int vecs = 0;
  int errs = 0;
  int ph[2] = '{0, 0};
  int cnt[2] = '{0, 0};
  logic [17:0] res[2], pend[2];
  bit armed = 1'b0;
  logic [15:0] corner[4] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};
  seg_adder_mc #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(a[0]), .b(b[0]),
    .cin(cin[0]), .sub(sub[0]), .out_valid(ov[0]), .out_ready(orr[0]), .s(s16),
    .co(co[0]), .ovf(ovf[0]), .busy(bz[0]));
  seg_adder_mc #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(a[1][7:0]), .b(b[1][7:0]),
    .cin(cin[1]), .sub(sub[1]), .out_valid(ov[1]), .out_ready(orr[1]), .s(s8),
    .co(co[1]), .ovf(ovf[1]), .busy(bz[1]));
  // {ovf, co, s} from plain unsigned/signed integer arithmetic at width w
  function automatic logic [17:0] ref_op(int w, logic [15:0] x, logic [15:0] y, logic ci, logic sb);
    longint m = (longint'(1) << w) - 1;
    longint h = longint'(1) << (w - 1);
    longint ux = longint'(x) & m;
    longint uy = longint'(y) & m;
    longint sx = ux >= h ? ux - (m + 1) : ux;
    longint sy = uy >= h ? uy - (m + 1) : uy;
    longint r = sb ? ux - uy : ux + uy + longint'(ci);
    longint sr = sb ? sx - sy : sx + sy + longint'(ci);
    logic c = sb ? (ux >= uy) : (r > m);
    logic o = (sr < -h) || (sr >= h);
    return {o, c, 16'(r & m)};
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk)
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        ph[k] = 0;
        res[k] = '0;
        armed = 1'b1;
      end else if (ph[k] == 0) begin
        if (iv[k]) begin
          pend[k] = ref_op(k ? 8 : 16, a[k], b[k], cin[k], sub[k]);
          cnt[k] = k ? 1 : 4;
          ph[k] = 1;
        end
      end else if (ph[k] == 1) begin
        cnt[k]--;
        if (cnt[k] == 0) begin
          ph[k] = 2;
          res[k] = pend[k];
        end
      end else if (orr[k]) ph[k] = 0;
    end
  always @(negedge clk)
    if (armed)
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("out_valid%0d", k), 32'(ov[k]), 32'(ph[k] == 2));
        chk($sformatf("in_ready%0d", k), 32'(ir[k]), 32'(ph[k] == 0));
        chk($sformatf("busy%0d", k), 32'(bz[k]), 32'(ph[k] != 0));
        if (ph[k] != 1)
          chk($sformatf("result%0d", k), 32'({ovf[k], co[k], k ? {8'h00, s8} : s16}), 32'(res[k]));
      end
  task automatic do_op(input int k, input logic [15:0] x, input logic [15:0] y, input logic ci,
                       input logic sb, input int hold, input bit keep, input logic [15:0] nx,
                       input logic [15:0] ny, output logic [31:0] got, output int lat);
    int t = 0;
    while (!ir[k] && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("accept_wait", 32'(ir[k]), 32'd1);
    a[k] = x;
    b[k] = y;
    cin[k] = ci;
    sub[k] = sb;
    iv[k] = 1'b1;
    @(negedge clk);
    iv[k] = 1'b0;
    a[k] = 16'($urandom);
    b[k] = 16'($urandom);
    lat = 0;
    while (!ov[k] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("done_wait", 32'(ov[k]), 32'd1);
    got = 32'({ovf[k], co[k], k ? {8'h00, s8} : s16});
    if (keep) begin
      a[k] = nx;
      b[k] = ny;
      cin[k] = 1'b0;
      sub[k] = 1'b0;
      iv[k] = 1'b1;
    end
    repeat (hold) @(negedge clk);
    orr[k] = 1'b1;
    @(negedge clk);
    orr[k] = 1'b0;
  endtask
  initial begin
    logic [31:0] got;
    int lat;
    logic [15:0] x, y;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0;
      orr[k] = 1'b0;
      cin[k] = 1'b0;
      sub[k] = 1'b0;
      a[k] = '0;
      b[k] = '0;
    end
    repeat (2) @(negedge clk);
    chk("reset_state", 32'({ov[0], bz[0], ir[0], s16}), 32'({3'b001, 16'h0000}));
    rst_n = 1'b1;
    do_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 16'h0, 16'h0, got, lat);
    chk("add_ff_1", got, 32'h00100);
    chk("latency16", 32'(lat), 32'd4);
    do_op(0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1, 1'b0, 16'h0, 16'h0, got, lat);
    chk("add_cin_wrap", got, 32'h10000);
    do_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 16'h0, 16'h0, got, lat);
    chk("add_ovf", got, 32'h28000);
    do_op(0, 16'h0005, 16'h0007, 1'b1, 1'b1, 0, 1'b0, 16'h0, 16'h0, got, lat);
    chk("sub_borrow", got, 32'h0FFFE);
    do_op(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 0, 1'b0, 16'h0, 16'h0, got, lat);
    chk("sub_ovf", got, 32'h37FFF);
    do_op(0, 16'h1234, 16'h1111, 1'b0, 1'b0, 10, 1'b1, 16'h0F0F, 16'hF0F2, got, lat);
    chk("held_result", got, 32'h02345);
    do_op(0, 16'h0F0F, 16'hF0F2, 1'b0, 1'b0, 0, 1'b0, 16'h0, 16'h0, got, lat);
    chk("queued_op", got, 32'h10001);
    a[0] = 16'hAAAA;
    b[0] = 16'h5555;
    iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_calc_reset", 32'({ov[0], bz[0], ir[0], s16}), 32'({3'b001, 16'h0000}));
    do_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0, 0, 1'b0, 16'h0, 16'h0, got, lat);
    chk("after_reset", got, 32'h05555);
    do_op(1, 16'h00FF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 16'h0, 16'h0, got, lat);
    chk("add8_wrap", got, 32'h10000);
    chk("latency8", 32'(lat), 32'd1);
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 1)) @(negedge clk);
      do_op(1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 2),
            1'b0, 16'h0, 16'h0, got, lat);
    end
    for (int i = 0; i < 300; i++) begin
      x = $urandom_range(0, 3) == 0 ? corner[$urandom_range(0, 3)] : 16'($urandom);
      y = $urandom_range(0, 3) == 0 ? corner[$urandom_range(0, 3)] : 16'($urandom);
      repeat ($urandom_range(0, 1)) @(negedge clk);
      do_op(0, x, y, 1'($urandom), 1'($urandom), $urandom_range(0, 3), 1'b0, 16'h0, 16'h0, got, lat);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
